// File: rtl/trap_ctrl.sv
// Trap sequencer for the machine-mode CSR file: arbitrates exceptions, mret and interrupts, then sequences the mstatus write and the PC redirect.
// Latency: redirect 3 cycles after the accept edge for a trap, 2 for mret. busy stalls the core, and requests seen outside IDLE are dropped.
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc_in,
  input  logic            time_compare,
  input  logic            sw_irq,
  input  logic            ext_irq,
  input  logic            done,
  input  logic [XLEN-1:0] next_pc,
  input  logic            exc_req,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  output logic [XLEN-1:0] mip,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mbadaddr,
  output logic [XLEN-1:0] mepc,
  output logic            mstatus_we,
  output logic [XLEN-1:0] mstatus_wdata,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  localparam int IRQ_SW  = 3;
  localparam int IRQ_TMR = 7;
  localparam int IRQ_EXT = 11;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    STATUS,
    JUMP,
    RSTATUS,
    RJUMP
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] mip_q, mip_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mbadaddr_q, mbadaddr_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mstatus_wdata_q, mstatus_wdata_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            mstatus_we_q, mstatus_we_d;
  logic            redirect_q, redirect_d;

  logic [XLEN-1:0] irq_pend;
  logic            irq_any;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] trap_status;
  logic [XLEN-1:0] mret_status;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] tvec_off;
  logic            tvec_vectored;

  // Pending is taken from the registered mip, so a source needs one cycle before it can trap.
  assign irq_pend = mip_q & mie & {XLEN{mstatus[3]}};
  assign irq_any  = irq_pend[IRQ_EXT] | irq_pend[IRQ_SW] | irq_pend[IRQ_TMR];

  always_comb begin
    irq_code = 4'(IRQ_TMR);
    if (irq_pend[IRQ_EXT]) begin
      irq_code = 4'(IRQ_EXT);
    end else if (irq_pend[IRQ_SW]) begin
      irq_code = 4'(IRQ_SW);
    end
  end

  always_comb begin
    trap_status        = mstatus;
    trap_status[7]     = mstatus[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = 2'b11;
    mret_status        = mstatus;
    mret_status[3]     = mstatus[7];
    mret_status[7]     = 1'b1;
  end

  // Only mode 1 vectors, and only for interrupts; modes 2/3 fall back to direct.
  assign tvec_base     = {mtvec[XLEN-1:2], 2'b00};
  assign tvec_off      = {{(XLEN-6){1'b0}}, mcause_q[3:0], 2'b00};
  assign tvec_vectored = (mtvec[1:0] == 2'b01) && mcause_q[XLEN-1];

  always_comb begin
    state_d          = state_q;
    mip_d            = '0;
    mip_d[IRQ_SW]    = sw_irq;
    mip_d[IRQ_TMR]   = time_compare;
    mip_d[IRQ_EXT]   = ext_irq;
    mcause_d         = mcause_q;
    mbadaddr_d       = mbadaddr_q;
    mepc_d           = mepc_q;
    mstatus_wdata_d  = mstatus_wdata_q;
    redirect_pc_d    = redirect_pc_q;
    mstatus_we_d     = 1'b0;
    redirect_d       = 1'b0;
    busy             = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (exc_req) begin
          state_d        = SAVE;
          mcause_d       = '0;
          mcause_d[3:0]  = exc_cause;
          mepc_d         = exc_pc;
          mbadaddr_d     = exc_tval;
          busy           = 1'b1;
        end else if (mret) begin
          state_d         = RSTATUS;
          mstatus_we_d    = 1'b1;
          mstatus_wdata_d = mret_status;
          busy            = 1'b1;
        end else if (done && irq_any) begin
          state_d            = SAVE;
          mcause_d           = '0;
          mcause_d[XLEN-1]   = 1'b1;
          mcause_d[3:0]      = irq_code;
          mepc_d             = next_pc;
          mbadaddr_d         = '0;
          busy               = 1'b1;
        end
      end
      SAVE: begin
        state_d         = STATUS;
        mstatus_we_d    = 1'b1;
        mstatus_wdata_d = trap_status;
        busy            = 1'b1;
      end
      STATUS: begin
        state_d       = JUMP;
        redirect_d    = 1'b1;
        redirect_pc_d = tvec_vectored ? (tvec_base + tvec_off) : tvec_base;
        busy          = 1'b1;
      end
      JUMP: begin
        state_d = IDLE;
        busy    = 1'b1;
      end
      RSTATUS: begin
        state_d       = RJUMP;
        redirect_d    = 1'b1;
        redirect_pc_d = mepc_in;
        busy          = 1'b1;
      end
      RJUMP: begin
        state_d = IDLE;
        busy    = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      mip_q           <= '0;
      mcause_q        <= '0;
      mbadaddr_q      <= '0;
      mepc_q          <= '0;
      mstatus_wdata_q <= '0;
      redirect_pc_q   <= '0;
      mstatus_we_q    <= 1'b0;
      redirect_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      mip_q           <= mip_d;
      mcause_q        <= mcause_d;
      mbadaddr_q      <= mbadaddr_d;
      mepc_q          <= mepc_d;
      mstatus_wdata_q <= mstatus_wdata_d;
      redirect_pc_q   <= redirect_pc_d;
      mstatus_we_q    <= mstatus_we_d;
      redirect_q      <= redirect_d;
    end
  end

  assign mip           = mip_q;
  assign mcause        = mcause_q;
  assign mbadaddr      = mbadaddr_q;
  assign mepc          = mepc_q;
  assign mstatus_we    = mstatus_we_q;
  assign mstatus_wdata = mstatus_wdata_q;
  assign redirect      = redirect_q;
  assign redirect_pc   = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected mstatus writes and redirects are queued at request time
// and matched, value and cycle, as the DUT produces them.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] mstatus, mie, mtvec, mepc_in, next_pc, exc_pc, exc_tval;
  logic        time_compare, sw_irq, ext_irq, done, exc_req, mret;
  logic [3:0]  exc_cause;
  logic [31:0] mip, mcause, mbadaddr, mepc, mstatus_wdata, redirect_pc;
  logic        mstatus_we, redirect, busy;

  trap_ctrl #(.XLEN(32)) dut (
    .clk(clk), .resetn(resetn), .mstatus(mstatus), .mie(mie), .mtvec(mtvec),
    .mepc_in(mepc_in), .time_compare(time_compare), .sw_irq(sw_irq), .ext_irq(ext_irq),
    .done(done), .next_pc(next_pc), .exc_req(exc_req), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .mret(mret), .mip(mip), .mcause(mcause),
    .mbadaddr(mbadaddr), .mepc(mepc), .mstatus_we(mstatus_we),
    .mstatus_wdata(mstatus_wdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } ws_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] bad;
    int          cyc;
  } rd_t;

  ws_t ws_q[$];
  rd_t rd_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", tag, obs, exp, cyc);
  endtask

  // Scoreboard side: every mstatus write and every redirect must match the head of its queue.
  always @(negedge clk) begin
    if (mstatus_we === 1'b1) begin
      if (ws_q.size() == 0) chk("ws_unexpected", 32'd1, 32'd0);
      else begin
        ws_t e;
        e = ws_q.pop_front();
        chk("ws_dat", mstatus_wdata, e.dat);
        chk("ws_cyc", cyc, e.cyc);
      end
    end
    if (redirect === 1'b1) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else begin
        rd_t r;
        r = rd_q.pop_front();
        chk("rd_pc", redirect_pc, r.pc);
        chk("rd_mcause", mcause, r.cause);
        chk("rd_mepc", mepc, r.epc);
        chk("rd_mbad", mbadaddr, r.bad);
        chk("rd_cyc", cyc, r.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_trap(input logic [31:0] ws, input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] epc, input logic [31:0] bad);
    ws_q.push_back('{dat: ws, cyc: cyc + 2});
    rd_q.push_back('{pc: pc, cause: cause, epc: epc, bad: bad, cyc: cyc + 3});
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      step();
      if (ws_q.size() == 0 && rd_q.size() == 0) break;
    end
    chk(tag, 32'((ws_q.size() == 0) && (rd_q.size() == 0)), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mip"}, mip, 32'd0);
    chk({tag, "_mcause"}, mcause, 32'd0);
    chk({tag, "_mbad"}, mbadaddr, 32'd0);
    chk({tag, "_mepc"}, mepc, 32'd0);
    chk({tag, "_wdata"}, mstatus_wdata, 32'd0);
    chk({tag, "_rpc"}, redirect_pc, 32'd0);
    chk({tag, "_we"}, 32'(mstatus_we), 32'd0);
    chk({tag, "_redir"}, 32'(redirect), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    mstatus = '0; mie = '0; mtvec = '0; mepc_in = '0; next_pc = '0;
    exc_pc = '0; exc_tval = '0; exc_cause = '0;
    time_compare = 0; sw_irq = 0; ext_irq = 0; done = 0; exc_req = 0; mret = 0;
    step(); step();
    chk_all_zero("reset");
    resetn = 1'b1;
    step();

    // 1: direct-mode timer interrupt; an exception during SAVE must be ignored.
    mtvec = 32'h100; mstatus = 32'h8; mie = 32'h80; time_compare = 1;
    step();
    chk("t1_mip", mip, 32'h80);
    chk("t1_busy_nodone", 32'(busy), 32'd0);
    done = 1; next_pc = 32'h40;
    #1;
    chk("t1_busy_accept", 32'(busy), 32'd1);
    push_trap(32'h1880, 32'h100, 32'h8000_0007, 32'h40, 32'h0);
    step();
    done = 0; time_compare = 0;
    exc_req = 1; exc_cause = 4'd5; exc_pc = 32'hBAD0; exc_tval = 32'hBAD1;
    step();
    exc_req = 0;
    chk("t1_mip_clear", mip, 32'h0);
    wait_drain("t1_drain");

    // 2: vectored mode, ext and timer together; ext wins.
    mtvec = 32'h201; mie = 32'h880; ext_irq = 1; time_compare = 1;
    step();
    chk("t2_mip", mip, 32'h880);
    done = 1; next_pc = 32'h80;
    push_trap(32'h1880, 32'h22C, 32'h8000_000B, 32'h80, 32'h0);
    step();
    done = 0; ext_irq = 0; time_compare = 0;
    wait_drain("t2_drain");

    // 3: exception beats a pending software interrupt; no vectoring for exceptions.
    mie = 32'h8; sw_irq = 1;
    step();
    chk("t3_mip", mip, 32'h8);
    done = 1; next_pc = 32'h90;
    exc_req = 1; exc_cause = 4'd2; exc_pc = 32'h1234; exc_tval = 32'hDEAD;
    push_trap(32'h1880, 32'h200, 32'h2, 32'h1234, 32'hDEAD);
    step();
    done = 0; exc_req = 0; sw_irq = 0;
    wait_drain("t3_drain");

    // 4: mret restores MIE from MPIE and leaves trap CSRs alone.
    mstatus = 32'h1880; mepc_in = 32'h40; mret = 1;
    ws_q.push_back('{dat: 32'h1888, cyc: cyc + 1});
    rd_q.push_back('{pc: 32'h40, cause: 32'h2, epc: 32'h1234, bad: 32'hDEAD, cyc: cyc + 2});
    step();
    mret = 0;
    wait_drain("t4_drain");
    chk("t4_mcause_hold", mcause, 32'h2);

    // 5: masking by MIE and by mie; no trap, mip still follows the sources.
    mstatus = 32'h0; mie = 32'h888; sw_irq = 1; time_compare = 1; ext_irq = 1; done = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_busy_mie0", 32'(busy), 32'd0);
    end
    chk("t5_mip", mip, 32'h888);
    mstatus = 32'h8; mie = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_busy_mask0", 32'(busy), 32'd0);
    end
    sw_irq = 0; time_compare = 0; ext_irq = 0; done = 0;
    step();

    // 6: reset while in STATUS aborts; a later request runs normally.
    mtvec = 32'h100; mstatus = 32'h8; mie = 32'h8; sw_irq = 1;
    step();
    done = 1; next_pc = 32'h44;
    ws_q.push_back('{dat: 32'h1880, cyc: cyc + 2});
    step();
    done = 0; sw_irq = 0;
    step();
    chk("t6_in_status_we", 32'(mstatus_we), 32'd1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk_all_zero("t6_async");
    step(); step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t6_no_leftover", 32'(ws_q.size() + rd_q.size()), 32'd0);
    sw_irq = 1;
    step();
    done = 1; next_pc = 32'h60;
    push_trap(32'h1880, 32'h100, 32'h8000_0003, 32'h60, 32'h0);
    step();
    done = 0; sw_irq = 0;
    wait_drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer in front of the machine-mode CSR file.
- Samples interrupt sources and the exception request, arbitrates them, and produces the trap-state CSR values (mip, mcause, mbadaddr, mepc).
- Drives mstatus updates for trap entry and mret.
- Issues a one-cycle PC redirect to the fetch stage.
- Stalls the core while a trap or mret sequence is in flight.

Parameters:
XLEN, 32, data width of all CSR-side buses

Ports:
clk  in  1  system clock
resetn  in  1  reset; asynchronous, active-low
mstatus  in  XLEN  current mstatus from CSR file (bit3 MIE, bit7 MPIE)
mie  in  XLEN  interrupt-enable mask from CSR file
mtvec  in  XLEN  trap vector base/mode from CSR file
mepc_in  in  XLEN  mepc value used as the mret return target (tie to mepc output)
time_compare  in  1  timer interrupt level (mtime >= mtimecmp)
sw_irq  in  1  software interrupt level
ext_irq  in  1  external interrupt level
done  in  1  instruction retired this cycle (instruction boundary)
next_pc  in  XLEN  PC of next instruction, valid with done
exc_req  in  1  synchronous exception request, single-cycle pulse
exc_cause  in  4  exception code
exc_pc  in  XLEN  PC of faulting instruction
exc_tval  in  XLEN  faulting address/value
mret  in  1  mret executed, single-cycle pulse
mip  out  XLEN  pending bits: bit3 sw, bit7 timer, bit11 ext; all other bits 0
mcause  out  XLEN  trap cause; bit31 = interrupt
mbadaddr  out  XLEN  trap value
mepc  out  XLEN  saved trap PC
mstatus_we  out  1  write strobe for mstatus
mstatus_wdata  out  XLEN  new mstatus value
redirect  out  1  one-cycle PC redirect pulse
redirect_pc  out  XLEN  redirect target
busy  out  1  core stall request

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - mip, mcause, mbadaddr, mepc, mstatus_wdata and redirect_pc are 0.
  - mstatus_we, redirect and busy are 0.
- mip is registered every cycle from the three source levels, giving 1-cycle latency. Sources are not latched: a source that deasserts clears its bit on the next cycle.
- Interrupt pending for source k: mip[k] & mie[k] & mstatus[3].
- FSM states: IDLE, SAVE, STATUS, JUMP, RSTATUS, RJUMP.
- IDLE arbitration, highest priority first:
  1. exc_req.
  2. mret.
  3. Interrupt with done=1. Interrupt priority is ext(11) > sw(3) > timer(7).
  - Losing requests are dropped; the core re-presents them.
- IDLE -> SAVE on an accepted exception or interrupt. In the same edge the block latches:
  - Exception: mcause={0,exc_cause zero-extended}, mepc=exc_pc, mbadaddr=exc_tval.
  - Interrupt: mcause={1,code}, mepc=next_pc, mbadaddr=0.
- SAVE -> STATUS:
  - In STATUS, mstatus_we=1 for exactly 1 cycle.
  - mstatus_wdata = mstatus with bit7 = old bit3, bit3 = 0, bits[12:11] = 2'b11.
- STATUS -> JUMP:
  - redirect=1 for exactly 1 cycle.
  - redirect_pc = {mtvec[31:2],2'b00} if mtvec[1:0]=0, or if the trap is an exception.
  - Otherwise (vectored interrupt): base + 4*code, 32-bit wrap-around, carry discarded.
- JUMP -> IDLE.
- mret path: IDLE -> RSTATUS -> RJUMP -> IDLE.
  - RSTATUS: mstatus_we=1 with bit3 = old bit7, bit7 = 1.
  - RJUMP: redirect=1, redirect_pc=mepc_in.
- busy=1 in every non-IDLE state, and combinationally in IDLE in the cycle a request is accepted.
- Requests arriving while not in IDLE are ignored.
- Trap entry = 4 cycles from request to redirect (accept, SAVE, STATUS, JUMP); mret = 3 cycles.
- mcause, mepc and mbadaddr hold their values until the next accepted trap; they are unchanged by mret.
- Reset mid-sequence aborts immediately. No partial mstatus write or redirect is issued after resetn rises.
- mtvec[1:0]=2 or 3 is treated as direct mode.

Test Plan:
1. Timer interrupt:
   - Stimulus: mtvec=0x100 (direct), mstatus=0x8, mie=0x80, time_compare=1, done=1, next_pc=0x40.
   - Response: mip=0x80 one cycle later; mcause=0x80000007; mepc=0x40; mstatus_wdata=0x1880; redirect_pc=0x100 four cycles after acceptance.
2. Vectored external interrupt:
   - Stimulus: mtvec=0x201, ext_irq=1 and time_compare=1 at the same time, mie=0x880.
   - Response: ext wins; mcause=0x8000000B; redirect_pc=0x22C.
3. Exception against interrupt:
   - Stimulus: exc_req with cause 2, exc_pc=0x1234, exc_tval=0xDEAD in the same cycle as a pending sw irq; mtvec=0x201.
   - Response: mcause=2, mbadaddr=0xDEAD, redirect_pc=0x200 (vectoring not applied to exceptions).
4. mret:
   - Stimulus: mstatus=0x1880, mepc_in=0x40, mret pulse.
   - Response: mstatus_wdata has bit3=1 and bit7=1; redirect_pc=0x40 three cycles after the pulse; mcause unchanged.
5. Masking:
   - Stimulus: mstatus bit3=0 with all sources high, or mie=0.
   - Response: no trap; busy stays 0; mip still reflects the sources.
6. Reset mid-operation:
   - Stimulus: assert resetn=0 while in STATUS.
   - Response: all outputs 0 asynchronously; no redirect after release; a new request after release is accepted normally.
